// File: rtl/microc_param.sv
// microc_param: parametrised single-cycle microcontroller datapath with register file, ALU, flags and return-address stack
module microc_param #(
  parameter int DATA_W = 8,
  parameter int NREGS = 16,
  parameter int PC_W = 10,
  parameter int STACK_DEPTH = 4,
  parameter int INSTR_W = 18
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               s_inc,
  input  logic               s_skip,
  input  logic               s_push,
  input  logic               s_pop,
  input  logic               s_inm,
  input  logic               we,
  input  logic [2:0]         ALUOp,
  output logic [PC_W-1:0]    pc_out,
  output logic [5:0]         Opcode,
  output logic               zero,
  output logic               carry,
  output logic               stack_err
);
  localparam int REG_AW = $clog2(NREGS);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [DATA_W-1:0] imm, a, b, res;
  logic [DATA_W:0]   sum, dif;
  logic [PC_W-1:0]   target, pc, pc1, pc2;
  logic [DATA_W-1:0] rf [NREGS];
  logic [PC_W-1:0]   stk [STACK_DEPTH];
  logic [SP_W-1:0]   sp;
  logic              empty, full, alu_c, do_pop, do_push, flag_we;
  assign rd      = instr[REG_AW-1:0];
  assign rs1     = instr[2*REG_AW-1:REG_AW];
  assign rs2     = instr[3*REG_AW-1:2*REG_AW];
  assign imm     = instr[DATA_W+REG_AW-1:REG_AW];
  assign target  = instr[PC_W-1:0];
  assign Opcode  = instr[INSTR_W-1 -: 6];
  assign pc_out  = pc;
  assign a       = rs1 == '0 ? '0 : rf[rs1];
  assign b       = rs2 == '0 ? '0 : rf[rs2];
  assign sum     = {1'b0, a} + {1'b0, b};
  assign dif     = {1'b0, a} - {1'b0, b};
  assign pc1     = pc + PC_W'(1);
  assign pc2     = pc + PC_W'(2);
  assign empty   = sp == '0;
  assign full    = sp == SP_W'(STACK_DEPTH);
  assign do_pop  = !reset && s_pop && !empty;
  assign do_push = !reset && !s_pop && s_push && !full;
  assign flag_we = we && !s_inm && rd != '0;
  assign alu_c   = ALUOp == 3'b010 ? sum[DATA_W] : ALUOp == 3'b011 ? dif[DATA_W] : 1'b0;
  always_comb begin
    case (ALUOp)
      3'b000:  res = a;
      3'b001:  res = ~a;
      3'b010:  res = sum[DATA_W-1:0];
      3'b011:  res = dif[DATA_W-1:0];
      3'b100:  res = a & b;
      3'b101:  res = a | b;
      3'b110:  res = -a;
      default: res = -b;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset)
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    else if (we && rd != '0)
      rf[rd] <= s_inm ? imm : res;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      zero  <= 1'b0;
      carry <= 1'b0;
    end else if (flag_we) begin
      zero  <= res == '0;
      carry <= alu_c;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= '0;
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      pc <= s_pop ? (empty ? pc1 : stk[0]) : s_push ? target : s_inc ? pc1 : s_skip ? pc2 : target;
      if (do_pop) sp <= sp - SP_W'(1);
      else if (do_push) sp <= sp + SP_W'(1);
      if ((s_pop && empty) || (!s_pop && s_push && full)) stack_err <= 1'b1;
    end
  end
  // top of stack lives in stk[0]; push shifts down, pop shifts up
  always_ff @(posedge clk) begin
    if (do_pop) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++) stk[i] <= stk[i+1];
    end else if (do_push) begin
      stk[0] <= pc1;
      for (int i = 1; i < STACK_DEPTH; i++) stk[i] <= stk[i-1];
    end
  end
endmodule

// File: doc/microc_param.md
# microc_param

Parametrised single-cycle microcontroller datapath, the next generation of `microc`. It holds the PC, register file, ALU, zero/carry flags and a new hardware return-address stack for call/return. It fetches from an external instruction port and is driven cycle-by-cycle by the external control unit through `s_inc`, `s_skip`, `s_push`, `s_pop`, `s_inm`, `we` and `ALUOp`. It also adds skip-next, a hardwired-zero r0 and stack-error reporting.

## Interface
- `DATA_W`, 8: data/register width.
- `NREGS`, 16: register count, power of two; `REG_AW = log2(NREGS)`.
- `PC_W`, 10: PC width; program space 2^PC_W words.
- `STACK_DEPTH`, 4: return-stack entries, ≥1.
- `INSTR_W`, 18: instruction width, ≥ 6 + max(3·REG_AW, DATA_W+REG_AW, PC_W).

Ports:
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `instr` in INSTR_W: instruction at `pc_out`.
- `s_inc` in 1: next PC = PC+1.
- `s_skip` in 1: next PC = PC+2.
- `s_push` in 1: call; push PC+1, jump to target.
- `s_pop` in 1: return; PC = stack top.
- `s_inm` in 1: writeback source = immediate (1) / ALU (0).
- `we` in 1: register-file write enable.
- `ALUOp` in 3: ALU operation.
- `pc_out` out PC_W: current PC register.
- `Opcode` out 6: `instr[INSTR_W-1:INSTR_W-6]`, combinational.
- `zero` out 1: registered zero flag.
- `carry` out 1: registered carry flag.
- `stack_err` out 1: sticky over/underflow flag.

## Operation
- Instruction fields: rd `instr[REG_AW-1:0]`; rs1 `instr[2·REG_AW-1:REG_AW]`; rs2 `instr[3·REG_AW-1:2·REG_AW]`; imm `instr[DATA_W+REG_AW-1:REG_AW]`; target `instr[PC_W-1:0]`.
- Register file:
  - Two combinational read ports (rs1→A, rs2→B) and one synchronous write port.
  - r0 always reads 0; writes to r0 are discarded.
- ALU, results truncated to DATA_W:
  - 000 A; 001 ~A; 010 A+B; 011 A−B; 100 A&B; 101 A|B; 110 −A; 111 −B.
- Writeback: when `we`=1, rd ← (`s_inm` ? imm : ALU result).
- Flags update only when `we`=1 and `s_inm`=0:
  - zero = (result == 0).
  - carry: add → carry-out of bit DATA_W-1; sub → 1 iff A < B unsigned; all other ops → 0.
  - Flags hold otherwise, including on writes to r0.
- Next-PC priority (highest first):
  - `s_pop`: stack non-empty → PC ← top, sp−1. Stack empty → PC ← PC+1, `stack_err` ← 1.
  - `s_push`: PC ← target. Stack not full → push PC+1, sp+1. Stack full → push discarded, `stack_err` ← 1, jump still taken.
  - `s_inc`: PC ← PC+1.
  - `s_skip`: PC ← PC+2.
  - none asserted: PC ← target (unconditional jump).
- `s_pop` with `s_push` in the same cycle: pop only, push ignored.
- PC arithmetic is modulo 2^PC_W. PC+1 from all-ones gives 0; PC+2 from all-ones gives 1. A pushed PC+1 wraps the same way.
- `stack_err` clears only on reset.

## Timing
- Single cycle: `instr` sampled with `pc_out`; PC, registers, flags and stack all update on the same rising edge.
- `Opcode` follows `instr` combinationally, zero latency.
- Register write is visible on read ports the cycle after the edge; no write-through bypass.
- Reset, synchronous and dominating all other inputs on that edge:
  - PC = 0, sp = 0 (stack empty), `zero` = 0, `carry` = 0, `stack_err` = 0.
  - All registers cleared.
  - Reset mid-call discards all stack contents.
- Stack pointer ranges 0..STACK_DEPTH. Full is sp == STACK_DEPTH; empty is sp == 0.

## Test plan
- Reset, then `s_inc`=1 for 3 cycles → `pc_out` 0,1,2,3; `zero`=`carry`=0.
- `s_inm`=1, `we`=1, imm=0xFF → r1; next imm=0x01 → r2. Then ALUOp=010, rs1=1, rs2=2, rd=3 → r3=0x00, `zero`=1, `carry`=1. Then ALUOp=011 with A=1, B=0xFF → `carry`=1.
- Write imm 0x5A to r0, then ALUOp=000 with rs1=0 into r4 → r4=0, `zero`=1.
- PC=5: `s_push`, target 0x20 → PC=0x20. Then `s_pop` → PC=6, `stack_err`=0.
- STACK_DEPTH+1 consecutive pushes → last push discarded, `stack_err`=1. Then STACK_DEPTH pops return the pushed addresses in reverse order. One extra pop → PC+1; `stack_err` remains 1 until reset.
- PC=2^PC_W−1 with `s_skip` → PC=1. Assert reset together with `s_push` → PC=0, stack empty, `stack_err`=0.
